// File: rtl/csr_rmw_pkg.sv
// Shared encodings for the CSR read-modify-write unit: op codes, FSM states
// and the location of the read-only field inside a CSR address.
package csr_rmw_pkg;

    typedef enum logic [1:0] {
        CSR_OP_RSVD = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam int         CSR_RO_HI  = 11;
    localparam int         CSR_RO_LO  = 10;
    localparam logic [1:0] CSR_RO_VAL = 2'b11;

    function automatic logic csr_is_ro(input logic [11:0] idx);
        return idx[CSR_RO_HI:CSR_RO_LO] == CSR_RO_VAL;
    endfunction

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational core of a CSR read-modify-write: new value, write enable
// and illegal-access flag from the op, operand and sampled old value.
module csr_rmw_alu
    import csr_rmw_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_op,
    input  logic            i_rs1is0,
    input  logic            i_ro,
    input  logic [XLEN-1:0] i_op1,
    input  logic [XLEN-1:0] i_rdata,
    input  logic            i_rd_ilgl,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_wr_en,
    output logic            o_ilgl
);

    logic w_wr_intent;

    always_comb begin
        o_wdata     = '0;
        w_wr_intent = 1'b0;
        case (csr_op_e'(i_op))
            CSR_OP_RW: begin
                o_wdata     = i_op1;
                w_wr_intent = 1'b1;
            end
            CSR_OP_RS: begin
                o_wdata     = i_op1 | i_rdata;
                w_wr_intent = ~i_rs1is0;
            end
            CSR_OP_RC: begin
                o_wdata     = ~i_op1 & i_rdata;
                w_wr_intent = ~i_rs1is0;
            end
            default: begin
                o_wdata     = '0;
                w_wr_intent = 1'b0;
            end
        endcase
        // Read-only space only matters when the instruction actually writes.
        o_ilgl  = (i_op == CSR_OP_RSVD) | i_rd_ilgl | (w_wr_intent & i_ro);
        o_wr_en = w_wr_intent & ~o_ilgl;
    end

endmodule

// File: rtl/csr_rmw_unit.sv
// Execute-stage CSR read-modify-write unit: one instruction at a time with a
// fixed read/compute/write/respond sequence, abortable until the write issues.
module csr_rmw_unit
    import csr_rmw_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter int CSR_IDX_WIDTH = 12,
    parameter int ZIMM_WIDTH    = 5,
    parameter int RD_LAT        = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     i_ready,
    input  logic [1:0]               i_op,
    input  logic                     i_rs1imm,
    input  logic                     i_rs1is0,
    input  logic [ZIMM_WIDTH-1:0]    i_zimm,
    input  logic [XLEN-1:0]          i_rs1,
    input  logic [CSR_IDX_WIDTH-1:0] i_csridx,
    input  logic [4:0]               i_rd_idx,
    input  logic                     i_flush,
    output logic                     csr_rd_en,
    output logic                     csr_wr_en,
    output logic [CSR_IDX_WIDTH-1:0] csr_idx,
    output logic [XLEN-1:0]          csr_wdata,
    input  logic [XLEN-1:0]          csr_rdata,
    input  logic                     csr_rd_ilgl,
    output logic                     o_valid,
    input  logic                     o_ready,
    output logic [XLEN-1:0]          o_dat,
    output logic                     o_ilgl,
    output logic [4:0]               o_rd_idx
);

    localparam int CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    state_e                   r_state;
    state_e                   w_state_next;
    logic [1:0]               r_op;
    logic                     r_rs1is0;
    logic [XLEN-1:0]          r_op1;
    logic [CSR_IDX_WIDTH-1:0] r_idx;
    logic [4:0]               r_rd_idx;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_csr_rd_en;
    logic                     r_csr_wr_en;
    logic [XLEN-1:0]          r_csr_wdata;
    logic                     r_o_valid;
    logic [XLEN-1:0]          r_o_dat;
    logic                     r_o_ilgl;

    logic                     w_accept;
    logic                     w_sample;
    logic [XLEN-1:0]          w_op1;
    logic [XLEN-1:0]          w_alu_wdata;
    logic                     w_alu_wr_en;
    logic                     w_alu_ilgl;

    assign i_ready  = (r_state == ST_IDLE) & rst_n;
    assign w_accept = (r_state == ST_IDLE) & i_valid;
    assign w_op1    = i_rs1imm ? {{(XLEN-ZIMM_WIDTH){1'b0}}, i_zimm} : i_rs1;

    // The cycle in which read data is valid on the bus; a flush wins over it.
    assign w_sample = ~i_flush &
                      ((RD_LAT == 0) ? (r_state == ST_READ)
                                     : ((r_state == ST_WAIT) && (r_cnt == CNT_W'(1))));

    csr_rmw_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .i_op      (r_op),
        .i_rs1is0  (r_rs1is0),
        .i_ro      (csr_is_ro(r_idx[11:0])),
        .i_op1     (r_op1),
        .i_rdata   (csr_rdata),
        .i_rd_ilgl (csr_rd_ilgl),
        .o_wdata   (w_alu_wdata),
        .o_wr_en   (w_alu_wr_en),
        .o_ilgl    (w_alu_ilgl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_valid) w_state_next = ST_READ;
            ST_READ: begin
                if (i_flush)          w_state_next = ST_IDLE;
                else if (RD_LAT == 0) w_state_next = ST_WRITE;
                else                  w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_flush)                  w_state_next = ST_IDLE;
                else if (r_cnt == CNT_W'(1))  w_state_next = ST_WRITE;
            end
            ST_WRITE: w_state_next = ST_RESP;
            ST_RESP:  if (o_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op        <= '0;
            r_rs1is0    <= 1'b0;
            r_op1       <= '0;
            r_idx       <= '0;
            r_rd_idx    <= '0;
            r_cnt       <= '0;
            r_csr_rd_en <= 1'b0;
            r_csr_wr_en <= 1'b0;
            r_csr_wdata <= '0;
            r_o_valid   <= 1'b0;
            r_o_dat     <= '0;
            r_o_ilgl    <= 1'b0;
        end else begin
            r_csr_rd_en <= w_accept;
            r_csr_wr_en <= w_sample & w_alu_wr_en;
            if (w_accept) begin
                r_op     <= i_op;
                r_rs1is0 <= i_rs1is0;
                r_op1    <= w_op1;
                r_idx    <= i_csridx;
                r_rd_idx <= i_rd_idx;
            end
            if (r_state == ST_READ) begin
                r_cnt <= CNT_W'(RD_LAT);
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_sample) begin
                r_csr_wdata <= w_alu_wdata;
                r_o_dat     <= w_alu_ilgl ? '0 : csr_rdata;
                r_o_ilgl    <= w_alu_ilgl;
            end
            if (r_state == ST_WRITE) begin
                r_o_valid <= 1'b1;
            end else if ((r_state == ST_RESP) && o_ready) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    assign csr_rd_en = r_csr_rd_en;
    assign csr_wr_en = r_csr_wr_en;
    assign csr_idx   = r_idx;
    assign csr_wdata = r_csr_wdata;
    assign o_valid   = r_o_valid;
    assign o_dat     = r_o_dat;
    assign o_ilgl    = r_o_ilgl;
    assign o_rd_idx  = r_rd_idx;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Scoreboard bench for csr_rmw_unit: a driver pushes expected bus/response
// events computed from a plain CSR-array model; a monitor pops and compares.
module tb_csr_rmw_unit;

    localparam int XLEN   = 32;
    localparam int IW     = 12;
    localparam int ZW     = 5;
    localparam int RD_LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            i_ready;
    logic [1:0]      i_op = '0;
    logic            i_rs1imm = 1'b0;
    logic            i_rs1is0 = 1'b0;
    logic [ZW-1:0]   i_zimm = '0;
    logic [XLEN-1:0] i_rs1 = '0;
    logic [IW-1:0]   i_csridx = '0;
    logic [4:0]      i_rd_idx = '0;
    logic            i_flush = 1'b0;
    logic            csr_rd_en, csr_wr_en;
    logic [IW-1:0]   csr_idx;
    logic [XLEN-1:0] csr_wdata, csr_rdata;
    logic            csr_rd_ilgl;
    logic            o_valid;
    logic            o_ready = 1'b1;
    logic [XLEN-1:0] o_dat;
    logic            o_ilgl;
    logic [4:0]      o_rd_idx;

    csr_rmw_unit #(.XLEN(XLEN), .CSR_IDX_WIDTH(IW), .ZIMM_WIDTH(ZW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_op(i_op),
        .i_rs1imm(i_rs1imm), .i_rs1is0(i_rs1is0), .i_zimm(i_zimm), .i_rs1(i_rs1),
        .i_csridx(i_csridx), .i_rd_idx(i_rd_idx), .i_flush(i_flush),
        .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_idx(csr_idx),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_rd_ilgl(csr_rd_ilgl),
        .o_valid(o_valid), .o_ready(o_ready), .o_dat(o_dat), .o_ilgl(o_ilgl),
        .o_rd_idx(o_rd_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- CSR bus model: read data appears RD_LAT cycles after the strobe
    bit [31:0] bus_mem [4096];
    bit [31:0] ref_mem [4096];
    bit        pipe_v  [4];
    bit [11:0] pipe_i  [4];
    bit [31:0] garbage;
    bit        src_v;
    bit [11:0] src_i;

    always @(posedge clk) begin
        pipe_v[0] <= csr_rd_en;
        pipe_i[0] <= csr_idx;
        for (int i = 1; i < 4; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_i[i] <= pipe_i[i-1];
        end
        if (csr_wr_en) bus_mem[csr_idx] <= csr_wdata;
        garbage <= $urandom;
    end

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign src_v = csr_rd_en;
            assign src_i = csr_idx;
        end else begin : g_latn
            assign src_v = pipe_v[RD_LAT-1];
            assign src_i = pipe_i[RD_LAT-1];
        end
    endgenerate

    assign csr_rdata   = src_v ? bus_mem[src_i] : garbage;
    assign csr_rd_ilgl = src_v ? (src_i == 12'h7FF) : garbage[0];

    // ---------------- scoreboard queues
    typedef struct { int cyc; logic [11:0] idx; logic [31:0] dat; } bus_ev_t;
    typedef struct { int cyc; logic [31:0] dat; logic ilgl; logic [4:0] rd; } rsp_ev_t;
    bus_ev_t q_rd[$];
    bus_ev_t q_wr[$];
    rsp_ev_t q_rsp[$];

    // ---------------- o_ready driver
    int hold_cycles = 0;
    bit rnd_ready = 0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hold_cycles > 0 && o_valid) begin
                o_ready = 1'b0;
                hold_cycles--;
            end else begin
                o_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
        end
    end

    // ---------------- monitor
    bit        stall_prev = 0;
    logic [31:0] p_dat;
    logic        p_ilgl;
    logic [4:0]  p_rd;
    bus_ev_t     m_bev;
    rsp_ev_t     m_rev;

    always @(negedge clk) begin
        if (rst_n) begin
            if (csr_rd_en) begin
                chk("rd_expected", 32'(q_rd.size() > 0), 1);
                if (q_rd.size() > 0) begin
                    m_bev = q_rd.pop_front();
                    chk("rd_cycle", cyc, m_bev.cyc);
                    chk("rd_idx", 32'(csr_idx), 32'(m_bev.idx));
                end
            end
            if (csr_wr_en) begin
                chk("wr_expected", 32'(q_wr.size() > 0), 1);
                if (q_wr.size() > 0) begin
                    m_bev = q_wr.pop_front();
                    chk("wr_cycle", cyc, m_bev.cyc);
                    chk("wr_idx", 32'(csr_idx), 32'(m_bev.idx));
                    chk("wr_data", csr_wdata, m_bev.dat);
                    $display("write idx=%h data=%h cycle=%0d", csr_idx, csr_wdata, cyc);
                end
            end
            if (o_valid) begin
                if (stall_prev) begin
                    chk("hold_dat", o_dat, p_dat);
                    chk("hold_ilgl", 32'(o_ilgl), 32'(p_ilgl));
                    chk("hold_rd", 32'(o_rd_idx), 32'(p_rd));
                    chk("hold_i_ready", 32'(i_ready), 0);
                end else begin
                    chk("rsp_expected", 32'(q_rsp.size() > 0), 1);
                    if (q_rsp.size() > 0) begin
                        m_rev = q_rsp.pop_front();
                        chk("rsp_cycle", cyc, m_rev.cyc);
                        chk("rsp_dat", o_dat, m_rev.dat);
                        chk("rsp_ilgl", 32'(o_ilgl), 32'(m_rev.ilgl));
                        chk("rsp_rd", 32'(o_rd_idx), 32'(m_rev.rd));
                        $display("resp dat=%h ilgl=%0b rd=%0d cycle=%0d", o_dat, o_ilgl, o_rd_idx, cyc);
                    end
                end
                stall_prev = !o_ready;
                p_dat  = o_dat;
                p_ilgl = o_ilgl;
                p_rd   = o_rd_idx;
            end else begin
                stall_prev = 0;
            end
        end else begin
            stall_prev = 0;
        end
    end

    // ---------------- driver with reference model
    bit b2b = 0;
    int last_hs = -1;

    // abort_kind: 0 none, 1 flush, 2 reset; abort_k = cycles after READ entry
    task automatic issue(input logic [1:0] op, input bit imm, input bit is0,
                         input logic [4:0] zimm, input logic [31:0] rs1,
                         input logic [11:0] idx, input logic [4:0] rd,
                         input int abort_kind, input int abort_k);
        int n;
        int hs;
        logic [31:0] op1, old, nw;
        bit intent, ilgl, completes;
        n = 0;
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_rs1imm = imm; i_rs1is0 = is0;
        i_zimm = zimm; i_rs1 = rs1; i_csridx = idx; i_rd_idx = rd;
        while (!i_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", 32'(n < 200), 1);
        if (n >= 200) begin
            i_valid = 1'b0;
            return;
        end
        hs  = cyc;
        old = ref_mem[idx];
        op1 = imm ? {27'd0, zimm} : rs1;
        intent = (op == 2'b01) || (op != 2'b00 && !is0);
        ilgl   = (op == 2'b00) || (idx == 12'h7FF) || (intent && idx >= 12'hC00);
        completes = (abort_kind == 0) || (abort_kind == 1 && abort_k > RD_LAT);
        q_rd.push_back('{hs + 1, idx, 32'd0});
        if (completes) begin
            if (intent && !ilgl) begin
                case (op)
                    2'b01:   nw = op1;
                    2'b10:   nw = old | op1;
                    default: nw = old & ~op1;
                endcase
                ref_mem[idx] = nw;
                q_wr.push_back('{hs + 2 + RD_LAT, idx, nw});
            end
            q_rsp.push_back('{hs + 3 + RD_LAT, ilgl ? 32'd0 : old, ilgl, rd});
        end
        $display("issue op=%0d imm=%0b is0=%0b op1=%h idx=%h rd=%0d abort=%0d/%0d cycle=%0d",
                 op, imm, is0, op1, idx, rd, abort_kind, abort_k, hs);
        if (b2b && last_hs >= 0) chk("throughput", hs - last_hs, 4 + RD_LAT);
        last_hs = hs;
        @(negedge clk);
        i_valid = 1'b0; i_op = 2'($urandom); i_rs1 = $urandom; i_csridx = 12'($urandom);
        i_zimm = 5'($urandom); i_rd_idx = 5'($urandom); i_rs1imm = 1'($urandom);
        if (abort_kind != 0) begin
            while (cyc < hs + 1 + abort_k) @(negedge clk);
            if (abort_kind == 1) begin
                i_flush = 1'b1;
                @(negedge clk);
                i_flush = 1'b0;
                if (abort_k <= RD_LAT) chk("idle_after_flush", 32'(i_ready), 1);
            end else begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_mid_i_ready", 32'(i_ready), 0);
                chk("rst_mid_strobes", {30'd0, csr_rd_en, csr_wr_en}, 0);
                chk("rst_mid_idx", 32'(csr_idx), 0);
                chk("rst_mid_wdata", csr_wdata, 0);
                chk("rst_mid_resp", {25'd0, o_valid, o_ilgl, o_rd_idx}, 0);
                chk("rst_mid_dat", o_dat, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
    endtask

    localparam logic [11:0] IDX_LIST [8] = '{12'h340, 12'h341, 12'h342, 12'h300,
                                             12'h305, 12'hC00, 12'h7FF, 12'hF11};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] op;
        bit imm, is0;
        logic [4:0] zimm;
        logic [31:0] rs1;
        int ak, kk;
        for (int i = 0; i < 4096; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end
        bus_mem[12'h340] = 32'h12345678; ref_mem[12'h340] = 32'h12345678;
        bus_mem[12'h341] = 32'h000000A0; ref_mem[12'h341] = 32'h000000A0;
        bus_mem[12'h342] = 32'h000000FF; ref_mem[12'h342] = 32'h000000FF;

        #3;
        chk("rst_i_ready", 32'(i_ready), 0);
        chk("rst_strobes", {30'd0, csr_rd_en, csr_wr_en}, 0);
        chk("rst_idx_wdata", csr_wdata | 32'(csr_idx), 0);
        chk("rst_resp", {25'd0, o_valid, o_ilgl, o_rd_idx}, 0);
        chk("rst_dat", o_dat, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_i_ready", 32'(i_ready), 1);

        // directed back-to-back set
        b2b = 1; last_hs = -1;
        issue(2'b01, 0, 0, 5'd0, 32'hDEADBEEF, 12'h340, 5'd1, 0, 0);
        issue(2'b10, 1, 0, 5'd5, 32'h0,        12'h341, 5'd2, 0, 0);
        issue(2'b11, 0, 0, 5'd0, 32'h0000000F, 12'h342, 5'd3, 0, 0);
        issue(2'b10, 0, 1, 5'd0, 32'h0,        12'h340, 5'd4, 0, 0);
        issue(2'b01, 0, 0, 5'd0, 32'h55AA55AA, 12'hC00, 5'd5, 0, 0);
        issue(2'b01, 0, 0, 5'd0, 32'h11111111, 12'h7FF, 5'd6, 0, 0);
        issue(2'b00, 0, 0, 5'd0, 32'h22222222, 12'h340, 5'd7, 0, 0);
        b2b = 0;

        // response held off for five cycles
        hold_cycles = 5;
        issue(2'b01, 0, 0, 5'd0, 32'hCAFEF00D, 12'h305, 5'd8, 0, 0);

        // flush in READ, each WAIT cycle, WRITE and RESP
        for (int k = 0; k <= RD_LAT + 2; k++)
            issue(2'b01, 0, 0, 5'd0, 32'hF0000000 | k, 12'h300, 5'(9 + k), 1, k);

        // reset in the first WAIT cycle, then a clean instruction
        issue(2'b01, 0, 0, 5'd0, 32'hBADBAD00, 12'h341, 5'd20, 2, 1);
        b2b = 0; last_hs = -1;
        issue(2'b10, 0, 0, 5'd0, 32'h00000F00, 12'h341, 5'd21, 0, 0);

        // randomized traffic with random output backpressure
        rnd_ready = 1;
        for (int t = 0; t < 60; t++) begin
            op   = 2'($urandom);
            imm  = 1'($urandom);
            zimm = 5'($urandom);
            rs1  = $urandom;
            is0  = ($urandom_range(0, 5) == 0);
            if (is0) begin zimm = 5'd0; rs1 = 32'd0; end
            ak = ($urandom_range(0, 5) == 0) ? 1 : 0;
            kk = $urandom_range(0, RD_LAT + 2);
            issue(op, imm, is0, zimm, rs1, IDX_LIST[$urandom_range(0, 7)], 5'($urandom), ak, kk);
        end
        rnd_ready = 0;

        n = 0;
        while ((q_rd.size() + q_wr.size() + q_rsp.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("drain_rd", q_rd.size(), 0);
        chk("drain_wr", q_wr.size(), 0);
        chk("drain_rsp", q_rsp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
